tryx_resp_tracker: RTL and testbench
====================================

// Module: tryx_resp_tracker
// PURPOSE
//  Response-side counterpart of the per-core TRYX user-tag controller. Passively
//  snoops the cluster AXI master port. Records which AW/AR bursts carry a non-zero
//  TRYX user tag, matches them to their B / last-R beats, and produces the per-core
//  axi_xresp_valid/axi_xresp_slverr pulses the controller captures.
//  Monitor only: never drives ready/valid, never stalls the bus.
// PARAMETERS
//  NB_CORES         4  cores; core index = axi id[CORE_IDX_W-1:0], CORE_IDX_W=$clog2(NB_CORES)
//  AXI_USER_WIDTH   6  AxUSER width; tag "tryx" = (AxUSER != 0)
//  AXI_ID_WIDTH     4  AXI ID width, >= CORE_IDX_W
//  MAX_OUTSTANDING  2  flag-FIFO depth per core per direction (>=1)
// PORTS
//  clk_i                 in   1                  clock
//  rst_ni                in   1                  async reset, active low
//  aw_valid_i/aw_ready_i in   1/1                AW handshake
//  aw_id_i               in   AXI_ID_WIDTH       AW id
//  aw_user_i             in   AXI_USER_WIDTH     AW user
//  ar_valid_i/ar_ready_i in   1/1                AR handshake
//  ar_id_i               in   AXI_ID_WIDTH       AR id
//  ar_user_i             in   AXI_USER_WIDTH     AR user
//  b_valid_i/b_ready_i   in   1/1                B handshake
//  b_id_i                in   AXI_ID_WIDTH       B id
//  b_resp_i              in   2                  B resp
//  r_valid_i/r_ready_i   in   1/1                R handshake
//  r_id_i                in   AXI_ID_WIDTH       R id
//  r_resp_i              in   2                  R resp
//  r_last_i              in   1                  R last beat
//  axi_xresp_valid_o     out  NB_CORES           1-cycle pulse: tagged txn completed
//  axi_xresp_slverr_o    out  NB_CORES           error flag, qualified by valid
//  protocol_err_o        out  NB_CORES           sticky: FIFO overflow/underflow
// BEHAVIOUR
//  - Reset: all outputs 0, all FIFOs empty, sticky flags cleared. Reset mid-burst
//    discards all tracking; responses for pre-reset requests then count as underflow.
//  - Push: AW (AR) handshake with core index < NB_CORES pushes flag (user!=0) into
//    that core's write (read) FIFO. Index >= NB_CORES is ignored on every channel.
//  - Pop: B handshake pops the write FIFO. R handshake with r_last_i=1 pops the read
//    FIFO. Non-last R beats only OR their error into a per-core read-error accumulator.
//  - Error of a completion:
//    - write: b_resp_i==SLVERR.
//    - read: SLVERR on any beat of the burst, including last.
//    - Accumulator clears on pop.
//  - Output: if the popped flag is 1, axi_xresp_valid_o[c]=1 exactly 1 cycle after the
//    pop handshake (registered), with slverr = error. Untagged pops produce no pulse.
//  - B and last-R pop for the same core in the same cycle:
//    - one pulse if either is tagged;
//    - slverr = OR of the errors of the tagged ones only.
//  - Push and pop in the same cycle on the same FIFO are both performed; occupancy unchanged.
//  - Push when full: flag dropped, protocol_err_o[c] set.
//  - Pop when empty: no pulse, protocol_err_o[c] set.
//  - protocol_err_o clears only on reset.
//  - Ordering: AXI same-ID in-order rule makes a per-core FIFO sufficient.
// CONFIGURATION
//  TRYX_RESP_DECERR_EN defined: resp==DECERR (2'b11) also counts as error (resp[1]).
//  Undefined: only SLVERR (2'b10) is an error; DECERR completes with slverr=0.
// STRUCTURE
//  - tryx_pkg:
//    - RESP_OKAY/EXOKAY/SLVERR/DECERR localparams;
//    - function is_err(resp), which honours the macro.
//  - Sub-module tryx_flag_fifo: 1-bit FIFO with depth parameter and full/empty.
//    Instantiated 2*NB_CORES times.
// TESTING
//  1. Core 1: AW id=1 user=6'h2A, then B resp=SLVERR -> xresp_valid[1] pulse, slverr[1]=1, 1 cycle after B.
//  2. Core 0: AR user=0, R 4 beats OKAY last -> no pulse on any core, protocol_err=0.
//  3. Core 2: tagged AR, 4-beat R: beat1 SLVERR, last OKAY -> one pulse, slverr[2]=1.
//  4. Core 3: same-cycle tagged B OKAY + tagged last-R SLVERR -> single pulse, slverr[3]=1.
//  5. MAX_OUTSTANDING=2: three AW on core 0 without B -> protocol_err[0]=1.
//     Later B on core 1 with empty FIFO -> protocol_err[1]=1.
//  6. Tagged B resp=DECERR -> slverr=1 with TRYX_RESP_DECERR_EN, 0 without.

Source files
------------

// File: rtl/tryx_resp_tracker_pkg.sv
// tryx_resp_tracker_pkg: AXI response codes and the error classifier shared by the tracker.
// TRYX_RESP_DECERR_EN makes DECERR count as an error alongside SLVERR.
package tryx_resp_tracker_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic is_err(input logic [1:0] resp);
`ifdef TRYX_RESP_DECERR_EN
        return resp == RESP_SLVERR || resp == RESP_DECERR;
`else
        return resp == RESP_SLVERR;
`endif
    endfunction
endpackage

// File: rtl/tryx_resp_tracker_flag_fifo.sv
// tryx_resp_tracker_flag_fifo: 1-bit flag FIFO, shift-down storage so the head is always bit 0.
// A push is accepted while full if a pop frees a slot in the same cycle.
module tryx_resp_tracker_flag_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic flag_i,
    input  logic pop_i,
    output logic head_o,
    output logic full_o,
    output logic empty_o
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem, mem_nxt;
    logic [CW-1:0]    cnt, widx;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        widx    = cnt - CW'(do_pop);
        mem_nxt = do_pop ? mem >> 1 : mem;
        for (int i = 0; i < DEPTH; i++)
            if (do_push && widx == CW'(i)) mem_nxt[i] = flag_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem <= '0;
            cnt <= '0;
        end else begin
            mem <= mem_nxt;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_o  = mem[0];
    assign full_o  = cnt == CW'(DEPTH);
    assign empty_o = cnt == '0;
endmodule

// File: rtl/tryx_resp_tracker.sv
// tryx_resp_tracker: passive AXI snooper pairing TRYX-tagged AW/AR bursts with their B / last-R
// completions and pulsing per-core xresp valid/slverr. Optional macro: TRYX_RESP_DECERR_EN.
module tryx_resp_tracker
    import tryx_resp_tracker_pkg::*;
#(
    parameter int NB_CORES        = 4,
    parameter int AXI_USER_WIDTH  = 6,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      aw_valid_i,
    input  logic                      aw_ready_i,
    input  logic [AXI_ID_WIDTH-1:0]   aw_id_i,
    input  logic [AXI_USER_WIDTH-1:0] aw_user_i,
    input  logic                      ar_valid_i,
    input  logic                      ar_ready_i,
    input  logic [AXI_ID_WIDTH-1:0]   ar_id_i,
    input  logic [AXI_USER_WIDTH-1:0] ar_user_i,
    input  logic                      b_valid_i,
    input  logic                      b_ready_i,
    input  logic [AXI_ID_WIDTH-1:0]   b_id_i,
    input  logic [1:0]                b_resp_i,
    input  logic                      r_valid_i,
    input  logic                      r_ready_i,
    input  logic [AXI_ID_WIDTH-1:0]   r_id_i,
    input  logic [1:0]                r_resp_i,
    input  logic                      r_last_i,
    output logic [NB_CORES-1:0]       axi_xresp_valid_o,
    output logic [NB_CORES-1:0]       axi_xresp_slverr_o,
    output logic [NB_CORES-1:0]       protocol_err_o
);
    localparam int CORE_IDX_W = $clog2(NB_CORES);
    // Core index lives in the low id bits; masking keeps the full id visible to lint.
    localparam logic [AXI_ID_WIDTH-1:0] IDX_MASK = AXI_ID_WIDTH'((1 << CORE_IDX_W) - 1);

    logic                b_err, r_err;
    logic [NB_CORES-1:0] aw_hit, ar_hit, b_hit, r_hit, rl_hit;
    logic [NB_CORES-1:0] w_head, w_full, w_empty, r_head, r_full, r_empty;
    logic [NB_CORES-1:0] w_tag, rd_tag, rd_acc, err_d, perr_d;

    assign b_err = is_err(b_resp_i);
    assign r_err = is_err(r_resp_i);

    for (genvar c = 0; c < NB_CORES; c++) begin : g_core
        assign aw_hit[c] = aw_valid_i && aw_ready_i && (aw_id_i & IDX_MASK) == AXI_ID_WIDTH'(c);
        assign ar_hit[c] = ar_valid_i && ar_ready_i && (ar_id_i & IDX_MASK) == AXI_ID_WIDTH'(c);
        assign b_hit[c]  = b_valid_i && b_ready_i && (b_id_i & IDX_MASK) == AXI_ID_WIDTH'(c);
        assign r_hit[c]  = r_valid_i && r_ready_i && (r_id_i & IDX_MASK) == AXI_ID_WIDTH'(c);
        assign rl_hit[c] = r_hit[c] && r_last_i;

        tryx_resp_tracker_flag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_wr_fifo (
            .clk_i(clk_i), .rst_ni(rst_ni),
            .push_i(aw_hit[c]), .flag_i(aw_user_i != '0), .pop_i(b_hit[c]),
            .head_o(w_head[c]), .full_o(w_full[c]), .empty_o(w_empty[c])
        );
        tryx_resp_tracker_flag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_rd_fifo (
            .clk_i(clk_i), .rst_ni(rst_ni),
            .push_i(ar_hit[c]), .flag_i(ar_user_i != '0), .pop_i(rl_hit[c]),
            .head_o(r_head[c]), .full_o(r_full[c]), .empty_o(r_empty[c])
        );

        assign w_tag[c]  = b_hit[c] && !w_empty[c] && w_head[c];
        assign rd_tag[c] = rl_hit[c] && !r_empty[c] && r_head[c];
        assign err_d[c]  = (w_tag[c] && b_err) || (rd_tag[c] && (rd_acc[c] || r_err));
        assign perr_d[c] = (aw_hit[c] && w_full[c] && !(b_hit[c] && !w_empty[c]))
                         || (ar_hit[c] && r_full[c] && !(rl_hit[c] && !r_empty[c]))
                         || (b_hit[c] && w_empty[c]) || (rl_hit[c] && r_empty[c]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            axi_xresp_valid_o  <= '0;
            axi_xresp_slverr_o <= '0;
            protocol_err_o     <= '0;
            rd_acc             <= '0;
        end else begin
            axi_xresp_valid_o  <= w_tag | rd_tag;
            axi_xresp_slverr_o <= err_d;
            protocol_err_o     <= protocol_err_o | perr_d;
            rd_acc             <= r_last_i ? rd_acc & ~r_hit : rd_acc | (r_hit & {NB_CORES{r_err}});
        end
    end
endmodule

// File: tb/tb_tryx_resp_tracker.sv
// tb_tryx_resp_tracker: table-driven bus events with a pulse scoreboard for tryx_resp_tracker.
// Honours TRYX_RESP_DECERR_EN when predicting DECERR completions.
module tb_tryx_resp_tracker;
    logic       clk_i = 1'b0, rst_ni = 1'b0;
    logic       aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i;
    logic       b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
    logic [3:0] aw_id_i, ar_id_i, b_id_i, r_id_i;
    logic [5:0] aw_user_i, ar_user_i;
    logic [1:0] b_resp_i, r_resp_i;
    logic [3:0] axi_xresp_valid_o, axi_xresp_slverr_o, protocol_err_o;

    always #5 clk_i = ~clk_i;

    tryx_resp_tracker #(.NB_CORES(4), .AXI_USER_WIDTH(6), .AXI_ID_WIDTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i), .aw_id_i(aw_id_i), .aw_user_i(aw_user_i),
        .ar_valid_i(ar_valid_i), .ar_ready_i(ar_ready_i), .ar_id_i(ar_id_i), .ar_user_i(ar_user_i),
        .b_valid_i(b_valid_i), .b_ready_i(b_ready_i), .b_id_i(b_id_i), .b_resp_i(b_resp_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_id_i(r_id_i), .r_resp_i(r_resp_i),
        .r_last_i(r_last_i),
        .axi_xresp_valid_o(axi_xresp_valid_o), .axi_xresp_slverr_o(axi_xresp_slverr_o),
        .protocol_err_o(protocol_err_o)
    );

    typedef struct packed { logic v; logic [3:0] id; logic [5:0] user; } ax_t;
    typedef struct packed { logic v; logic [3:0] id; logic [1:0] resp; logic last; } rs_t;
    typedef struct { ax_t aw; ax_t ar; rs_t b; rs_t r; logic rdy; logic [3:0] ev, ee, ep; } vec_t;
    typedef struct { int core; logic err; int cyc; } exp_t;

    localparam ax_t NA = '0;
    localparam rs_t NR = '0;
    localparam logic [1:0] OK = 2'b00, SLV = 2'b10, DER = 2'b11;
`ifdef TRYX_RESP_DECERR_EN
    localparam logic [3:0] DEC0 = 4'b0001;
`else
    localparam logic [3:0] DEC0 = 4'b0000;
`endif

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0, errors = 0, cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic ax_t ax(logic [3:0] id, logic [5:0] user);
        return '{1'b1, id, user};
    endfunction
    function automatic rs_t rs(logic [3:0] id, logic [1:0] resp, logic last);
        return '{1'b1, id, resp, last};
    endfunction
    function automatic void add(ax_t aw, ax_t ar, rs_t b, rs_t r, logic rdy,
                                logic [3:0] ev, logic [3:0] ee, logic [3:0] ep);
        tbl.push_back('{aw, ar, b, r, rdy, ev, ee, ep});
    endfunction

    // Every pulse must match a queued expectation for that core, in the predicted cycle.
    always @(negedge clk_i) begin
        int found;
        for (int c = 0; c < 4; c++) begin
            if (axi_xresp_valid_o[c] === 1'b1) begin
                found = -1;
                for (int i = 0; i < sb.size(); i++)
                    if (found < 0 && sb[i].core == c) found = i;
                checks++;
                if (found < 0) begin
                    errors++;
                    $display("FAIL pulse_core%0d unexpected pulse slverr=%0b cyc=%0d", c, axi_xresp_slverr_o[c], cyc);
                end else begin
                    if (axi_xresp_slverr_o[c] !== sb[found].err || cyc != sb[found].cyc) begin
                        errors++;
                        $display("FAIL pulse_core%0d got slverr=%0b cyc=%0d expected slverr=%0b cyc=%0d",
                                 c, axi_xresp_slverr_o[c], cyc, sb[found].err, sb[found].cyc);
                    end
                    sb.delete(found);
                end
            end
        end
        checks++;
        if ((axi_xresp_slverr_o & ~axi_xresp_valid_o) != 4'b0) begin
            errors++;
            $display("FAIL slverr_qual got slverr=%b valid=%b expected slverr within valid",
                     axi_xresp_slverr_o, axi_xresp_valid_o);
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL pulse_core%0d missing pulse, expected slverr=%0b cyc=%0d", sb[i].core, sb[i].err, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    task automatic idle();
        {aw_valid_i, ar_valid_i, b_valid_i, r_valid_i, r_last_i} = '0;
        {aw_ready_i, ar_ready_i, b_ready_i, r_ready_i} = 4'hF;
        {aw_id_i, ar_id_i, b_id_i, r_id_i} = '0;
        {aw_user_i, ar_user_i, b_resp_i, r_resp_i} = '0;
    endtask

    task automatic check4(string name, logic [3:0] got, logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, got, want);
        end
    endtask

    task automatic apply(vec_t v);
        @(negedge clk_i);
        {aw_valid_i, aw_id_i, aw_user_i} = v.aw;
        {ar_valid_i, ar_id_i, ar_user_i} = v.ar;
        {b_valid_i, b_id_i, b_resp_i} = {v.b.v, v.b.id, v.b.resp};
        {r_valid_i, r_id_i, r_resp_i, r_last_i} = v.r;
        {aw_ready_i, ar_ready_i, b_ready_i, r_ready_i} = {4{v.rdy}};
        for (int c = 0; c < 4; c++)
            if (v.ev[c]) sb.push_back('{c, v.ee[c], cyc + 1});
        @(negedge clk_i);
        idle();
        check4("protocol_err", protocol_err_o, v.ep);
    endtask

    initial begin
        idle();
        add(ax(4'd1, 6'h2A), NA, NR, NR, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        add(NA, NA, rs(4'd1, SLV, 1'b0), NR, 1'b1, 4'b0010, 4'b0010, 4'b0000);
        add(NA, ax(4'd0, 6'h00), NR, NR, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) add(NA, NA, NR, rs(4'd0, OK, 1'b0), 1'b1, 4'b0000, 4'b0000, 4'b0000);
        add(NA, NA, NR, rs(4'd0, OK, 1'b1), 1'b1, 4'b0000, 4'b0000, 4'b0000);
        add(NA, ax(4'd2, 6'h05), NR, NR, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        add(NA, NA, NR, rs(4'd2, OK, 1'b0), 1'b1, 4'b0000, 4'b0000, 4'b0000);
        add(NA, NA, NR, rs(4'd2, SLV, 1'b0), 1'b1, 4'b0000, 4'b0000, 4'b0000);
        add(NA, NA, NR, rs(4'd2, OK, 1'b0), 1'b1, 4'b0000, 4'b0000, 4'b0000);
        add(NA, NA, NR, rs(4'd2, OK, 1'b1), 1'b1, 4'b0100, 4'b0100, 4'b0000);
        add(ax(4'd3, 6'h01), ax(4'd3, 6'h01), NR, NR, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        add(NA, NA, rs(4'd3, OK, 1'b0), rs(4'd3, SLV, 1'b1), 1'b1, 4'b1000, 4'b1000, 4'b0000);
        add(ax(4'd0, 6'h01), NA, NR, NR, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        add(ax(4'd0, 6'h07), NA, NR, NR, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        add(ax(4'd0, 6'h03), NA, NR, NR, 1'b1, 4'b0000, 4'b0000, 4'b0001);
        add(NA, NA, rs(4'd1, OK, 1'b0), NR, 1'b1, 4'b0000, 4'b0000, 4'b0011);
        add(NA, NA, rs(4'd0, OK, 1'b0), NR, 1'b1, 4'b0001, 4'b0000, 4'b0011);
        add(NA, NA, rs(4'd0, DER, 1'b0), NR, 1'b1, 4'b0001, DEC0, 4'b0011);
        add(ax(4'd2, 6'h01), NA, NR, NR, 1'b0, 4'b0000, 4'b0000, 4'b0011);
        add(NA, NA, rs(4'd2, OK, 1'b0), NR, 1'b1, 4'b0000, 4'b0000, 4'b0111);
        add(ax(4'd3, 6'h01), NA, NR, NR, 1'b1, 4'b0000, 4'b0000, 4'b0111);
        add(ax(4'd3, 6'h00), NA, rs(4'd3, OK, 1'b0), NR, 1'b1, 4'b1000, 4'b0000, 4'b0111);
        add(ax(4'd3, 6'h01), NA, rs(4'd3, SLV, 1'b0), NR, 1'b1, 4'b0000, 4'b0000, 4'b0111);
        add(NA, NA, rs(4'd3, SLV, 1'b0), NR, 1'b1, 4'b1000, 4'b1000, 4'b0111);
        add(ax(4'd3, 6'h00), ax(4'd3, 6'h01), NR, NR, 1'b1, 4'b0000, 4'b0000, 4'b0111);
        add(NA, NA, rs(4'd3, SLV, 1'b0), rs(4'd3, OK, 1'b1), 1'b1, 4'b1000, 4'b0000, 4'b0111);
        add(ax(4'd13, 6'h09), NA, NR, NR, 1'b1, 4'b0000, 4'b0000, 4'b0111);
        add(NA, NA, rs(4'd5, OK, 1'b0), NR, 1'b1, 4'b0010, 4'b0000, 4'b0111);
        add(NA, ax(4'd2, 6'h01), NR, NR, 1'b1, 4'b0000, 4'b0000, 4'b0111);
        add(NA, NA, NR, rs(4'd2, OK, 1'b1), 1'b1, 4'b0100, 4'b0000, 4'b0111);

        repeat (2) @(negedge clk_i);
        check4("reset_valid", axi_xresp_valid_o, 4'b0000);
        check4("reset_slverr", axi_xresp_slverr_o, 4'b0000);
        check4("reset_perr", protocol_err_o, 4'b0000);
        rst_ni = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Reset while a tagged write is outstanding: its B must then be an underflow.
        apply('{ax(4'd1, 6'h11), NA, NR, NR, 1'b1, 4'b0000, 4'b0000, 4'b0111});
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check4("async_reset_perr", protocol_err_o, 4'b0000);
        @(negedge clk_i);
        check4("mid_reset_valid", axi_xresp_valid_o, 4'b0000);
        rst_ni = 1'b1;
        apply('{NA, NA, rs(4'd1, SLV, 1'b0), NR, 1'b1, 4'b0000, 4'b0000, 4'b0010});

        repeat (3) @(negedge clk_i);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
